// File: rtl/fib_seq_engine.sv
// fib_seq_engine: computes the n-th term of a two-seed additive recurrence.
// The seeds are the SEED0/SEED1 parameters (mode=0) or the seed_a/seed_b ports (mode=1).
// The engine has a start/busy/done handshake and a sticky overflow flag.
module fib_seq_engine #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_W    = 12,
    parameter int unsigned SEED0  = 1,
    parameter int unsigned SEED1  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_W-1:0]    n_in,
    input  logic              mode,
    input  logic [DATA_W-1:0] seed_a,
    input  logic [DATA_W-1:0] seed_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [N_W-1:0]    cnt;
    logic [N_W-1:0]    n_lat;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] seed0_sel;
    logic [DATA_W-1:0] seed1_sel;

    // One extra bit on the adder exposes the carry-out for overflow tracking
    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
    end

    // Seed selection; mode only matters on the cycle a start is accepted
    always_comb begin
        seed0_sel = mode ? seed_a : DATA_W'(SEED0);
        seed1_sel = mode ? seed_b : DATA_W'(SEED1);
    end

    // Control FSM with datapath registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
            a        <= '0;
            b        <= '0;
            cnt      <= '0;
            n_lat    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        n_lat    <= n_in;
                        a        <= seed0_sel;
                        b        <= seed1_sel;
                        cnt      <= N_W'(1);
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // cnt stops at n_lat, so it never needs to wrap even for n = 2^N_W-1
                    if (cnt < n_lat) begin
                        a        <= b;
                        b        <= sum[DATA_W-1:0];
                        cnt      <= cnt + N_W'(1);
                        overflow <= overflow | sum[DATA_W];
                    end else begin
                        result <= (n_lat == '0) ? a : b;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_seq_engine.sv
// Testbench for fib_seq_engine.
// A sequence-level reference model is compared against the DUT on every cycle,
// and directed runs check results and latencies against hand-computed values.
module tb_fib_seq_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] n_in;
    logic        mode;
    logic [15:0] seed_a;
    logic [15:0] seed_b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        overflow;

    logic        s_start;
    logic [3:0]  s_n;
    logic        s_mode;
    logic [7:0]  s_seed_a;
    logic [7:0]  s_seed_b;
    logic        s_busy;
    logic        s_done;
    logic [7:0]  s_result;
    logic        s_overflow;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    fib_seq_engine dut (
        .clk(clk), .reset(reset), .start(start), .n_in(n_in), .mode(mode),
        .seed_a(seed_a), .seed_b(seed_b), .busy(busy), .done(done),
        .result(result), .overflow(overflow)
    );

    fib_seq_engine #(.DATA_W(8), .N_W(4)) dut_small (
        .clk(clk), .reset(reset), .start(s_start), .n_in(s_n), .mode(s_mode),
        .seed_a(s_seed_a), .seed_b(s_seed_b), .busy(s_busy), .done(s_done),
        .result(s_result), .overflow(s_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Term n of the recurrence t0=s0, t1=s1, t(i)=t(i-1)+t(i-2) mod 2^w,
    // plus whether any of those additions exceeded 2^w-1.
    function automatic void fib_model(input int n, input longint s0, input longint s1,
                                      input int w, output longint term, output bit ovf);
        longint m;
        longint x;
        longint y;
        longint z;
        m   = (longint'(1) << w) - 1;
        x   = s0 & m;
        y   = s1 & m;
        ovf = 1'b0;
        if (n == 0) begin
            term = x;
        end else begin
            for (int i = 2; i <= n; i++) begin
                z = x + y;
                if (z > m) ovf = 1'b1;
                x = y;
                y = z & m;
            end
            term = y;
        end
    endfunction

    // Reference model state, expressed as remaining busy cycles and elapsed steps
    int          m_left = 0;
    int          m_step = 0;
    int          m_n    = 0;
    longint      m_s0   = 0;
    longint      m_s1   = 0;
    logic [15:0] m_res  = '0;
    bit          m_ovf  = 1'b0;
    bit          m_done = 1'b0;

    // Advance the reference model on each rising edge using the sampled inputs
    always @(posedge clk) begin : model_blk
        longint t;
        bit     o;
        int     adds;
        if (reset) begin
            m_left <= 0;
            m_step <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_ovf  <= 1'b0;
        end else if (m_left == 0) begin
            m_done <= 1'b0;
            if (start) begin
                m_n    <= int'(n_in);
                m_s0   <= mode ? longint'(seed_a) : 1;
                m_s1   <= mode ? longint'(seed_b) : 1;
                m_left <= (n_in == 0) ? 1 : int'(n_in);
                m_step <= 0;
                m_ovf  <= 1'b0;
            end
        end else begin
            // Additions completed once this step is done: n-1 in total, at most one per step
            adds = (m_n == 0) ? 0 : (((m_step + 1) < (m_n - 1)) ? (m_step + 1) : (m_n - 1));
            fib_model(adds + 1, m_s0, m_s1, 16, t, o);
            m_ovf <= o;
            if (m_left == 1) begin
                fib_model(m_n, m_s0, m_s1, 16, t, o);
                m_res  <= t[15:0];
                m_done <= 1'b1;
            end
            m_step <= m_step + 1;
            m_left <= m_left - 1;
        end
    end

    // Compare every DUT output with the model away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", busy, (m_left > 0) ? 1 : 0);
            check("cyc_done", done, m_done);
            check("cyc_result", result, m_res);
            check("cyc_overflow", overflow, m_ovf);
        end
    end

    // Wait for done on the main DUT, then check latency, result and overflow
    task automatic wait_done(input string name, input bit drop_start, input longint exp_res,
                             input int exp_lat, input bit exp_ovf);
        int cyc;
        bit got;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (drop_start && cyc == 1) start = 1'b0;
            if (done) got = 1'b1;
        end
        check({name, "_done_seen"}, got, 1);
        check({name, "_latency"}, cyc, exp_lat);
        check({name, "_result"}, result, exp_res);
        check({name, "_overflow"}, overflow, exp_ovf);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t;
        bit     o;
        int     cyc;
        int     ndone;
        int     lat;
        bit     got;

        reset = 1'b1; start = 1'b0; n_in = '0; mode = 1'b0; seed_a = '0; seed_b = '0;
        s_start = 1'b0; s_n = '0; s_mode = 1'b0; s_seed_a = '0; s_seed_b = '0;

        // Pin the reference model against hand-computed values
        fib_model(10, 1, 1, 16, t, o);  check("model_n10", t, 89);
        fib_model(23, 1, 1, 16, t, o);  check("model_n23", t, 46368); check("model_n23_ovf", o, 0);
        fib_model(24, 1, 1, 16, t, o);  check("model_n24", t, 9489);  check("model_n24_ovf", o, 1);
        fib_model(6, 2, 1, 16, t, o);   check("model_lucas6", t, 18);
        fib_model(15, 1, 1, 8, t, o);   check("model_w8_n15", t, 219); check("model_w8_ovf", o, 1);

        // Reset for two cycles, then idle with start low
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_overflow", overflow, 0);
        repeat (10) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_result", result, 0);

        // Default mode chain with back-to-back starts on each done
        mode = 1'b0; n_in = 12'd0; start = 1'b1;
        wait_done("n0", 1'b0, 1, 2, 1'b0);
        n_in = 12'd1;
        wait_done("n1", 1'b0, 1, 2, 1'b0);
        n_in = 12'd5;
        wait_done("n5", 1'b0, 8, 6, 1'b0);
        n_in = 12'd10;
        wait_done("n10", 1'b0, 89, 11, 1'b0);
        start = 1'b0;
        @(negedge clk);

        // Width boundary
        n_in = 12'd23; start = 1'b1;
        wait_done("n23", 1'b1, 46368, 24, 1'b0);
        @(negedge clk);
        n_in = 12'd24; start = 1'b1;
        wait_done("n24", 1'b1, 9489, 25, 1'b1);
        repeat (5) @(negedge clk);
        check("n24_ovf_held", overflow, 1);
        check("n24_result_held", result, 9489);

        // Lucas seeds with input disturbance and a start pulse while busy
        mode = 1'b1; seed_a = 16'd2; seed_b = 16'd1; n_in = 12'd6; start = 1'b1;
        ndone = 0; lat = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0; seed_a = 16'd100; n_in = 12'd3; mode = 1'b0;
            end
            if (c == 3) start = 1'b1;
            if (c == 4) start = 1'b0;
            if (done) begin
                ndone++;
                lat = c;
                check("lucas_result", result, 18);
            end
        end
        check("lucas_done_count", ndone, 1);
        check("lucas_latency", lat, 7);

        // Reset in the 5th RUN cycle of an n=20 run
        mode = 1'b0; n_in = 12'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("midrun_busy_before", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrun_busy_after", busy, 0);
        check("midrun_done_after", done, 0);
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrun_no_done", ndone, 0);
        n_in = 12'd3; start = 1'b1;
        wait_done("after_reset_n3", 1'b1, 3, 4, 1'b0);

        // Narrow instance: n = 2^N_W-1 must complete
        s_mode = 1'b0; s_n = 4'd15; s_start = 1'b1;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) s_start = 1'b0;
            if (s_done) got = 1'b1;
        end
        check("w8_done_seen", got, 1);
        check("w8_latency", cyc, 16);
        check("w8_result", s_result, 219);
        check("w8_overflow", s_overflow, 1);
        @(negedge clk);
        check("w8_busy_after", s_busy, 0);
        check("w8_done_after", s_done, 0);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
